// File: rtl/noc_packet_sink.sv
// noc_packet_sink: receive-side NoC endpoint. Accepts flits from a router
// local port, reassembles packets, checks routing/length/sequence/payload
// fields and keeps packet and error counters. Ready follows a fixed,
// registered stall pattern and never looks at valid.
module noc_packet_sink #(
    parameter int X_ID         = 0,
    parameter int Y_ID         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int STALL_PERIOD = 0
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  receive_valid,
    output logic                  receive_ready,
    input  logic [DATA_WIDTH-1:0] receive_flit,
    input  logic                  receive_is_header,
    input  logic                  receive_is_tail,
    output logic [7:0]            receive_num,
    output logic [7:0]            error_count,
    output logic                  error_flag,
    output logic [7:0]            last_src
);

    typedef enum logic {
        ST_IDLE,
        ST_BODY
    } state_t;

    localparam logic [3:0]  MY_X  = 4'(X_ID);
    localparam logic [3:0]  MY_Y  = 4'(Y_ID);
    localparam int unsigned CNT_W = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      seq_q, seq_d;
    logic [7:0]      src_q, src_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      exp_seq_q, exp_seq_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            ready_d;
    logic            flit_err;
    logic            complete;
    logic [7:0]      done_src;
    logic            xfer;

    // Header field views of the incoming flit.
    logic [3:0] h_dx, h_dy, h_sx, h_sy;
    logic [7:0] h_len, h_seq, b_idx, b_seq;

    assign h_dx  = receive_flit[3:0];
    assign h_dy  = receive_flit[7:4];
    assign h_sx  = receive_flit[11:8];
    assign h_sy  = receive_flit[15:12];
    assign h_len = receive_flit[23:16];
    assign h_seq = receive_flit[31:24];
    assign b_idx = receive_flit[7:0];
    assign b_seq = receive_flit[15:8];

    assign xfer = receive_valid & receive_ready;

    // Stall pattern: ready is low while the free-running counter sits at its
    // last value; ready is registered from the counter's next value.
    generate
        if (STALL_PERIOD < 2) begin : g_no_stall
            always_comb begin
                stall_cnt_d = '0;
                ready_d     = 1'b1;
            end
        end else begin : g_stall
            always_comb begin
                stall_cnt_d = (stall_cnt_q == CNT_W'(STALL_PERIOD - 1)) ? '0
                                                                         : stall_cnt_q + 1'b1;
                ready_d     = (stall_cnt_d != CNT_W'(STALL_PERIOD - 1));
            end
        end
    endgenerate

    // Packet checker: next state, latched header fields and per-flit error.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        len_d     = len_q;
        seq_d     = seq_q;
        src_d     = src_q;
        idx_d     = idx_q;
        exp_seq_d = exp_seq_q;
        flit_err  = 1'b0;
        complete  = 1'b0;
        done_src  = src_q;

        if (xfer) begin
            if (receive_is_header) begin
                // A header in BODY abandons the open packet (missing tail).
                flit_err  = (h_dx != MY_X) || (h_dy != MY_Y) ||
                            (h_seq != exp_seq_q) || (state_q == ST_BODY);
                exp_seq_d = h_seq + 8'd1;
                if (receive_is_tail) begin
                    flit_err = flit_err || (h_len != 8'd0);
                    complete = 1'b1;
                    done_src = {h_sy, h_sx};
                    state_d  = ST_IDLE;
                end else begin
                    flit_err = flit_err || (h_len == 8'd0);
                    len_d    = h_len;
                    seq_d    = h_seq;
                    src_d    = {h_sy, h_sx};
                    idx_d    = 8'd0;
                    state_d  = ST_BODY;
                end
            end else if (state_q == ST_BODY) begin
                idx_d    = idx_q + 8'd1;
                flit_err = (b_idx != idx_d) || (b_seq != seq_q);
                if (receive_is_tail) begin
                    flit_err = flit_err || (idx_d != len_q);
                    complete = 1'b1;
                    done_src = src_q;
                    state_d  = ST_IDLE;
                end else begin
                    flit_err = flit_err || (idx_d == len_q);
                end
            end else begin
                // Body flit with no open packet: orphan, discarded.
                flit_err = 1'b1;
            end
        end
    end

    // State, counters and flags; reset is synchronous, sampled on the edge.
    always_ff @(posedge noc_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge.
        if (!noc_rst_n) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            seq_q         <= '0;
            src_q         <= '0;
            idx_q         <= '0;
            exp_seq_q     <= '0;
            stall_cnt_q   <= '0;
            receive_ready <= 1'b0;
            receive_num   <= '0;
            error_count   <= '0;
            error_flag    <= 1'b0;
            last_src      <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            seq_q         <= seq_d;
            src_q         <= src_d;
            idx_q         <= idx_d;
            exp_seq_q     <= exp_seq_d;
            stall_cnt_q   <= stall_cnt_d;
            receive_ready <= ready_d;
            if (complete) begin
                receive_num <= receive_num + 8'd1;
                last_src    <= done_src;
            end
            if (flit_err) begin
                error_flag <= 1'b1;
                if (error_count != 8'hFF) error_count <= error_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_packet_sink.sv
// tb_noc_packet_sink: scoreboard bench. The driver pushes hand-computed
// expected outputs for each flit it issues; a monitor watches the handshake
// and compares the DUT outputs one cycle after every accepted flit.
module tb_noc_packet_sink;

    logic        clk;
    logic        rst_n;
    logic        drv_valid;
    logic        drv_hdr;
    logic        drv_tail;
    logic [31:0] drv_flit;
    logic        sel;           // 0: always-ready DUT, 1: stalling DUT

    logic        valid0, valid4;
    logic        r0, r4, f0, f4;
    logic [7:0]  n0, n4, e0, e4, s0, s4;
    logic        cur_ready, cur_flag;
    logic [7:0]  cur_num, cur_err, cur_src;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] num;
        logic [7:0] err;
        logic       flag;
        logic [7:0] src;
    } exp_t;

    exp_t exp_q[$];

    bit   rst_q;
    bit   low_seen;
    bit   low_en;

    assign valid0    = drv_valid & ~sel;
    assign valid4    = drv_valid & sel;
    assign cur_ready = sel ? r4 : r0;
    assign cur_num   = sel ? n4 : n0;
    assign cur_err   = sel ? e4 : e0;
    assign cur_flag  = sel ? f4 : f0;
    assign cur_src   = sel ? s4 : s0;

    noc_packet_sink #(.X_ID(1), .Y_ID(1), .DATA_WIDTH(32), .STALL_PERIOD(0)) dut0 (
        .noc_clk(clk), .noc_rst_n(rst_n),
        .receive_valid(valid0), .receive_ready(r0), .receive_flit(drv_flit),
        .receive_is_header(drv_hdr), .receive_is_tail(drv_tail),
        .receive_num(n0), .error_count(e0), .error_flag(f0), .last_src(s0)
    );

    noc_packet_sink #(.X_ID(1), .Y_ID(1), .DATA_WIDTH(32), .STALL_PERIOD(4)) dut4 (
        .noc_clk(clk), .noc_rst_n(rst_n),
        .receive_valid(valid4), .receive_ready(r4), .receive_flit(drv_flit),
        .receive_is_header(drv_hdr), .receive_is_tail(drv_tail),
        .receive_num(n4), .error_count(e4), .error_flag(f4), .last_src(s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] hdr(input int dx, dy, sx, sy, len, seq);
        return {8'(seq), 8'(len), 4'(sy), 4'(sx), 4'(dy), 4'(dx)};
    endfunction

    function automatic logic [31:0] body(input int k, seq);
        return {16'h0, 8'(seq), 8'(k)};
    endfunction

    // Issue one flit, holding it until the selected DUT accepts it.
    task automatic send(input logic h, input logic t, input logic [31:0] flit,
                        input int e_num, input int e_err, input logic e_flag,
                        input logic [7:0] e_src);
        exp_t e;
        bit   acc;
        int   waited;
        e.num  = 8'(e_num);
        e.err  = 8'(e_err);
        e.flag = e_flag;
        e.src  = e_src;
        exp_q.push_back(e);
        drv_valid = 1'b1;
        drv_hdr   = h;
        drv_tail  = t;
        drv_flit  = flit;
        acc       = 1'b0;
        waited    = 0;
        while (!acc && waited < 20) begin
            @(posedge clk);
            acc = cur_ready;
            waited++;
            @(negedge clk);
        end
        if (!acc) begin
            fail_now("handshake_timeout");
            void'(exp_q.pop_back());
        end
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        drv_hdr   = 1'b0;
        drv_tail  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        idle(2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", cur_ready, 0);
        check("rst_num",   cur_num,   0);
        check("rst_err",   cur_err,   0);
        check("rst_flag",  cur_flag,  0);
        check("rst_src",   cur_src,   0);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: one comparison set per accepted flit.
    always @(posedge clk) begin
        if (rst_n && drv_valid && cur_ready) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                fail_now("sb_unexpected_transfer");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_num",     cur_num,  e.num);
                check("error_count", cur_err, e.err);
                check("error_flag", cur_flag, e.flag);
                check("last_src",   cur_src,  e.src);
            end
        end
    end

    // Watch the always-ready DUT for any low ready once out of reset.
    always @(posedge clk) rst_q <= rst_n;
    always @(negedge clk) if (low_en && rst_q && !r0) low_seen = 1'b1;

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        drv_flit  = '0;
        low_en    = 1'b0;
        low_seen  = 1'b0;
        idle(1);

        // Clean stream, full throughput.
        reset_dut();
        low_en = 1'b1;
        for (int p = 0; p < 10; p++) begin
            send(1, 0, hdr(1, 1, 0, 0, 3, p), p, 0, 0, 8'h00);
            send(0, 0, body(1, p), p, 0, 0, 8'h00);
            send(0, 0, body(2, p), p, 0, 0, 8'h00);
            send(0, 1, body(3, p), p + 1, 0, 0, 8'h00);
        end
        idle(2);
        low_en = 1'b0;
        check("ready_never_low", low_seen, 0);

        // Single-flit packets, then one with a bad length.
        reset_dut();
        for (int s = 0; s < 4; s++)
            send(1, 1, hdr(1, 1, 2, 3, 0, s), s + 1, 0, 0, 8'h32);
        send(1, 1, hdr(1, 1, 2, 3, 2, 4), 5, 1, 1, 8'h32);

        // Missing tail, then orphan body flits.
        reset_dut();
        send(1, 0, hdr(1, 1, 1, 0, 2, 0), 0, 0, 0, 8'h00);
        send(0, 0, body(1, 0), 0, 0, 0, 8'h00);
        send(1, 0, hdr(1, 1, 4, 5, 1, 1), 0, 1, 1, 8'h00);
        send(0, 1, body(1, 1), 1, 1, 1, 8'h54);
        send(0, 0, body(1, 1), 1, 2, 1, 8'h54);
        send(0, 0, body(2, 1), 1, 3, 1, 8'h54);

        // Routing, sequence, payload and length faults.
        reset_dut();
        send(1, 0, hdr(0, 1, 0, 0, 1, 0), 0, 1, 1, 8'h00);   // dest mismatch
        send(0, 1, body(1, 0), 1, 1, 1, 8'h00);
        send(1, 0, hdr(1, 1, 6, 7, 1, 5), 1, 2, 1, 8'h00);   // seq jump 0->5
        send(0, 1, body(1, 5), 2, 2, 1, 8'h76);
        send(1, 1, hdr(1, 1, 0, 0, 0, 6), 3, 2, 1, 8'h00);   // expected_seq now 6
        send(1, 0, hdr(1, 1, 0, 0, 2, 7), 3, 2, 1, 8'h00);
        send(0, 0, body(9, 7), 3, 3, 1, 8'h00);              // bad index
        send(0, 1, body(2, 7), 4, 3, 1, 8'h00);
        send(1, 0, hdr(1, 1, 0, 0, 1, 8), 4, 3, 1, 8'h00);
        send(0, 0, body(1, 8), 4, 4, 1, 8'h00);              // idx==len, no tail
        send(0, 1, body(2, 8), 5, 5, 1, 8'h00);              // tail past len
        send(1, 1, hdr(0, 0, 0, 0, 0, 0), 6, 6, 1, 8'h00);   // two faults, one count

        // Backpressure: ready pattern, then 20 held-off packets.
        sel = 1'b1;
        reset_dut();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("stall_ready", r4, (k % 4 != 3) ? 1 : 0);
        end
        for (int p = 0; p < 20; p++) begin
            send(1, 0, hdr(1, 1, 1, 2, 5, p), p, 0, 0, (p == 0) ? 8'h00 : 8'h21);
            for (int k = 1; k <= 4; k++)
                send(0, 0, body(k, p), p, 0, 0, (p == 0) ? 8'h00 : 8'h21);
            send(0, 1, body(5, p), p + 1, 0, 0, 8'h21);
        end
        idle(2);
        sel = 1'b0;

        // Reset in the middle of a packet; leftover flits are orphans.
        reset_dut();
        send(1, 0, hdr(1, 1, 0, 0, 4, 0), 0, 0, 0, 8'h00);
        send(0, 0, body(1, 0), 0, 0, 0, 8'h00);
        send(0, 0, body(2, 0), 0, 0, 0, 8'h00);
        reset_dut();
        send(0, 0, body(3, 0), 0, 1, 1, 8'h00);
        send(0, 1, body(4, 0), 0, 2, 1, 8'h00);

        // Packet counter wrap, then error counter saturation.
        reset_dut();
        for (int i = 0; i < 256; i++)
            send(1, 1, hdr(1, 1, 2, 3, 0, i), (i + 1) % 256, 0, 0, 8'h32);
        for (int i = 0; i < 260; i++)
            send(0, 0, body(1, 0), 0, (i + 1 > 255) ? 255 : i + 1, 1, 8'h32);

        idle(3);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
